// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: decode-stage sequencer between fetch and execute.
// Holds one instruction and its PC, classifies the opcode for the immediate
// generator, and handles valid/ready flow control, flush and load-use bubbles.
// Optional feature: define DECODE_STALL_CNT_EN to add the stall_cycles counter.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// EMPTY   | no instruction held; fetch may deliver one
// FULL    | instruction held and offered to EX unless a load-use hazard is seen
// HAZARD  | one-cycle bubble; the held instruction is re-offered afterwards
module decode_stage_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instruction,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic [2:0]      id_encoding
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HAZARD = 2'd2
  } state_t;

  localparam logic [2:0] ENC_R       = 3'd0;
  localparam logic [2:0] ENC_I       = 3'd1;
  localparam logic [2:0] ENC_S       = 3'd2;
  localparam logic [2:0] ENC_B       = 3'd3;
  localparam logic [2:0] ENC_U       = 3'd4;
  localparam logic [2:0] ENC_J       = 3'd5;
  localparam logic [2:0] ENC_ILLEGAL = 3'd7;

  state_t     state;
  logic       haz_mask;   // set once the bubble for the held instruction has been paid
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       fire;
  logic       accept;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign rs1 = id_instruction[19:15];
  assign rs2 = id_instruction[24:20];

  // Opcode classification driving the immediate generator's format select
  always_comb begin
    id_encoding = ENC_ILLEGAL;
    case (id_instruction[6:0])
      7'b0110011:                                     id_encoding = ENC_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: id_encoding = ENC_I;
      7'b0100011:                                     id_encoding = ENC_S;
      7'b1100011:                                     id_encoding = ENC_B;
      7'b0110111, 7'b0010111:                         id_encoding = ENC_U;
      7'b1101111:                                     id_encoding = ENC_J;
      default:                                        id_encoding = ENC_ILLEGAL;
    endcase
  end

  // Load-use detection and handshake terms
  always_comb begin
    use_rs1 = (id_encoding == ENC_R) || (id_encoding == ENC_I) ||
              (id_encoding == ENC_S) || (id_encoding == ENC_B);
    use_rs2 = (id_encoding == ENC_R) || (id_encoding == ENC_S) ||
              (id_encoding == ENC_B);
    hazard  = (state == ST_FULL) && !haz_mask && ex_mem_read && (ex_rd != 5'd0) &&
              ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
    id_valid = (state == ST_FULL) && !hazard;
    fire     = id_valid && ex_ready;
    if_ready = (state == ST_EMPTY) || fire || flush;
    accept   = if_valid && if_ready && !flush;
  end

  // Sequencer: flush beats accept, accept beats fire/hazard progression
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_EMPTY;
      haz_mask       <= 1'b0;
      id_instruction <= NOP_INSTR;
      id_pc          <= '0;
    end else if (flush) begin
      state          <= ST_EMPTY;
      haz_mask       <= 1'b0;
      id_instruction <= NOP_INSTR;
    end else if (accept) begin
      state          <= ST_FULL;
      haz_mask       <= 1'b0;
      id_instruction <= if_instruction;
      id_pc          <= if_pc;
    end else begin
      case (state)
        ST_FULL: begin
          if (fire) begin
            state <= ST_EMPTY;
          end else if (hazard) begin
            state <= ST_HAZARD;
          end
        end
        ST_HAZARD: begin
          state    <= ST_FULL;
          haz_mask <= 1'b1;
        end
        default: state <= state;
      endcase
    end
  end

`ifdef DECODE_STALL_CNT_EN
  // Count cycles an instruction sits in FULL without leaving; survives flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
    end else if ((state == ST_FULL) && !fire) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Testbench for decode_stage_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a slot-level reference model.
module tb_decode_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instruction = '0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [2:0]  id_encoding;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  decode_stage_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .flush          (flush),
    .ex_ready       (ex_ready),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_encoding    (id_encoding)
`ifdef DECODE_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one instruction slot, a pending-bubble flag and a
  // "bubble already paid" flag for the instruction in the slot.
  bit          m_full;
  bit          m_bubble;
  bit          m_paid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_stall;

  function automatic logic [2:0] ref_enc(logic [31:0] ins);
    case (ins[6:0])
      7'h33:                      return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      default:                    return 3'd7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full   = 1'b0;
    m_bubble = 1'b0;
    m_paid   = 1'b0;
    m_instr  = NOP;
    m_pc     = '0;
    m_stall  = '0;
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  task automatic cyc();
    logic [2:0] e;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit haz, v, f, r, acc;
    #1;
    e   = ref_enc(m_instr);
    rs1 = m_instr[19:15];
    rs2 = m_instr[24:20];
    haz = m_full && !m_bubble && !m_paid && ex_mem_read && (ex_rd != 0) &&
          (((e <= 3'd3) && (ex_rd == rs1)) ||
           ((e == 3'd0 || e == 3'd2 || e == 3'd3) && (ex_rd == rs2)));
    v   = m_full && !m_bubble && !haz;
    f   = v && ex_ready;
    r   = !m_full || f || flush;
    acc = if_valid && r && !flush;
    chk("if_ready", 32'(if_ready), 32'(r));
    chk("id_valid", 32'(id_valid), 32'(v));
    chk("id_instruction", id_instruction, m_instr);
    chk("id_pc", id_pc, m_pc);
    chk("id_encoding", 32'(id_encoding), 32'(e));
`ifdef DECODE_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    @(posedge clk);
    if (m_full && !m_bubble && !f) m_stall = m_stall + 32'd1;
    if (flush) begin
      m_full   = 1'b0;
      m_bubble = 1'b0;
      m_instr  = NOP;
    end else if (acc) begin
      m_full   = 1'b1;
      m_bubble = 1'b0;
      m_paid   = 1'b0;
      m_instr  = if_instruction;
      m_pc     = if_pc;
    end else if (f) begin
      m_full = 1'b0;
    end else if (haz) begin
      m_bubble = 1'b1;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
      m_paid   = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    logic [6:0]  ops [11];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    ins        = $urandom;
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    ins[6:0]   = ops[$urandom_range(0, 10)];
    if_instruction = ins;
    if_pc          = $urandom & 32'hFFFF_FFFC;
    if_valid       = ($urandom_range(0, 9) < 7);
    ex_ready       = ($urandom_range(0, 3) != 0);
    ex_mem_read    = ($urandom_range(0, 9) < 4);
    ex_rd          = 5'($urandom_range(0, 3));
    flush          = ($urandom_range(0, 9) == 0);
  endtask

  logic [31:0] s2_ins [3];
  logic [2:0]  s2_enc [3];

  initial begin
    model_reset();
    #12;
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instruction", id_instruction, NOP);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_encoding", 32'(id_encoding), 32'd1);
`ifdef DECODE_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Single accept, one-cycle latency
    if_valid = 1'b1; if_instruction = 32'h0050_0093; if_pc = 32'h100; ex_ready = 1'b1;
    cyc();
    if_valid = 1'b0;
    #1;
    chk("s1_valid", 32'(id_valid), 32'd1);
    chk("s1_enc", 32'(id_encoding), 32'd1);
    cyc();

    // Back-to-back stream, zero bubbles
    s2_ins = '{32'h0020_81B3, 32'h0011_2223, 32'hFE00_0EE3};
    s2_enc = '{3'd0, 3'd2, 3'd3};
    if_valid = 1'b1; if_instruction = s2_ins[0]; if_pc = 32'h104;
    cyc();
    for (int i = 1; i < 3; i++) begin
      if_instruction = s2_ins[i]; if_pc = 32'h104 + 32'(4 * i);
      #1;
      chk("s2_enc", 32'(id_encoding), 32'(s2_enc[i-1]));
      chk("s2_ready", 32'(if_ready), 32'd1);
      cyc();
    end
    if_valid = 1'b0;
    #1;
    chk("s2_enc_last", 32'(id_encoding), 32'(s2_enc[2]));
    cyc();

    // Load-use hazard on rs1
    if_valid = 1'b1; if_instruction = 32'h0020_8133; if_pc = 32'h200;
    cyc();
    if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd1;
    #1;
    chk("s3_valid_hz", 32'(id_valid), 32'd0);
    chk("s3_ready_hz", 32'(if_ready), 32'd0);
    cyc();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    chk("s3_valid_bubble", 32'(id_valid), 32'd0);
    chk("s3_ready_bubble", 32'(if_ready), 32'd0);
    cyc();
    #1;
    chk("s3_valid_after", 32'(id_valid), 32'd1);
    cyc();

    // Back-pressure for three cycles, then fire and accept together
    if_valid = 1'b1; if_instruction = 32'h00A0_0113; if_pc = 32'h300; ex_ready = 1'b1;
    cyc();
    ex_ready = 1'b0; if_instruction = 32'h0030_0193; if_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s4_instr_hold", id_instruction, 32'h00A0_0113);
      chk("s4_pc_hold", id_pc, 32'h300);
      chk("s4_ready_low", 32'(if_ready), 32'd0);
      cyc();
    end
    ex_ready = 1'b1;
    #1;
    chk("s4_ready_fire", 32'(if_ready), 32'd1);
    cyc();
    if_valid = 1'b0;
    #1;
    chk("s4_new_instr", id_instruction, 32'h0030_0193);
    cyc();
`ifdef DECODE_STALL_CNT_EN
    chk("s6_stall_count", stall_cycles, 32'd4);
`endif

    // Flush with a fetch transfer while in HAZARD (rs2 hazard)
    if_valid = 1'b1; if_instruction = 32'h0020_8133; if_pc = 32'h400;
    cyc();
    if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd2;
    cyc();
    ex_mem_read = 1'b0; flush = 1'b1; if_valid = 1'b1;
    if_instruction = 32'h0050_0093; if_pc = 32'h404;
    cyc();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    chk("s5_valid", 32'(id_valid), 32'd0);
    chk("s5_instr_nop", id_instruction, NOP);
    chk("s5_ready", 32'(if_ready), 32'd1);
    cyc();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cyc();
    end

    // Asynchronous reset in the middle of a cycle
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_instr", id_instruction, NOP);
    chk("arst_pc", id_pc, 32'd0);
`ifdef DECODE_STALL_CNT_EN
    chk("arst_stall", stall_cycles, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
